// File: rtl/seven_seg_if.sv
// Digit-data and display-pin bundle between time-keeping logic and the seven-segment scanner.
// The driver side of the bus uses the master modport, the scanner uses slave.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_lz;
    logic                    load;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              segments;
    logic                    decimal;
    logic                    frame_tick;

    modport master (
        output digits, dp_in, blink_mask, blank_lz, load,
        input  anode, segments, decimal, frame_tick
    );

    modport slave (
        input  digits, dp_in, blink_mask, blank_lz, load,
        output anode, segments, decimal, frame_tick
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Self-timed N-digit common-anode scanner: double-buffered digit data, hex decode,
// per-digit decimal points, blinking and leading-zero blanking, all outputs registered.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    seven_seg_if.slave  bus
);
    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    function automatic logic [6:0] f_hex_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [PRE_W-1:0]        r_presc;
    logic [SLOT_W-1:0]       r_slot;
    logic [BLK_W-1:0]        r_blk_cnt;
    logic                    r_blink_phase;
    logic [4*NUM_DIGITS-1:0] r_sh_dig;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_bm;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_act_dig;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_bm;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_segments;
    logic                    r_decimal;
    logic                    r_frame_tick;

    logic                    w_tc;
    logic                    w_wrap;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_cur_dig;
    logic                    w_cur_dp;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_anode_sel;

    assign w_tc   = (r_presc == PRE_LAST);
    assign w_wrap = w_tc && (r_slot == SLOT_LAST);

    // Refresh prescaler and digit slot sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_slot  <= '0;
        end else begin
            if (w_tc) begin
                r_presc <= '0;
                r_slot  <= w_wrap ? '0 : r_slot + SLOT_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    // Blink timebase counts whole frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt     <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blk_cnt == BLK_LAST) begin
                r_blk_cnt     <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + BLK_W'(1);
            end
        end
    end

    // Shadow/active buffering: active data only ever changes on the frame wrap,
    // and a load on the wrap cycle itself goes straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_dig  <= '0;
            r_sh_dp   <= '0;
            r_sh_bm   <= '0;
            r_pending <= 1'b0;
            r_act_dig <= '0;
            r_act_dp  <= '0;
            r_act_bm  <= '0;
        end else begin
            if (bus.load) begin
                r_sh_dig <= bus.digits;
                r_sh_dp  <= bus.dp_in;
                r_sh_bm  <= bus.blink_mask;
            end
            if (w_wrap && bus.load) begin
                r_act_dig <= bus.digits;
                r_act_dp  <= bus.dp_in;
                r_act_bm  <= bus.blink_mask;
                r_pending <= 1'b0;
            end else if (w_wrap && r_pending) begin
                r_act_dig <= r_sh_dig;
                r_act_dp  <= r_sh_dp;
                r_act_bm  <= r_sh_bm;
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more-significant digit is 0 with no dp
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run & (r_act_dig[4*k +: 4] == 4'd0) & ~r_act_dp[k];
            if (k != 0) begin
                w_lz[k] = w_zero_run & bus.blank_lz;
            end
        end
    end

    assign w_cur_dig   = r_act_dig[{r_slot, 2'b00} +: 4];
    assign w_cur_dp    = r_act_dp[r_slot];
    assign w_blank     = (r_act_bm[r_slot] & r_blink_phase) | w_lz[r_slot];
    assign w_anode_sel = ~(NUM_DIGITS'(1) << r_slot);

    // Output register stage: one cycle behind the slot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode      <= '1;
            r_segments   <= 7'b1111111;
            r_decimal    <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap;
            if (w_blank) begin
                r_anode    <= '1;
                r_segments <= 7'b1111111;
                r_decimal  <= 1'b1;
            end else begin
                r_anode    <= w_anode_sel;
                r_segments <= f_hex_decode(w_cur_dig);
                r_decimal  <= ~w_cur_dp;
            end
        end
    end

    assign bus.anode      = r_anode;
    assign bus.segments   = r_segments;
    assign bus.decimal    = r_decimal;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: random and directed stimulus against a frame-arithmetic model.
module tb_seven_seg_scanner;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BD    = 2;
    localparam int FRAME = ND * RD;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seven_seg_if #(.NUM_DIGITS(ND)) bus();

    seven_seg_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int k;

    logic [15:0] m_act_d, m_sh_d;
    logic [3:0]  m_act_dp, m_act_bm, m_sh_dp, m_sh_bm;
    bit          m_has_sh;
    logic [12:0] exp_vec;
    logic [12:0] obs_vec;
    assign obs_vec = {bus.anode, bus.segments, bus.decimal, bus.frame_tick};

    logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Expected {anode, segments, decimal} for digit s of the data shown in a frame
    function automatic logic [11:0] model_out(input int s, input logic [15:0] d,
                                              input logic [3:0] dp, input logic [3:0] bm,
                                              input bit blz, input bit ph);
        bit lz;
        logic [3:0] an;
        logic [3:0] v;
        lz = blz && (s != 0);
        for (int j = s; j < ND; j++) begin
            if (d[4*j +: 4] != 4'd0 || dp[j]) lz = 1'b0;
        end
        if ((bm[s] && ph) || lz) return 12'hFFF;
        an = 4'hF;
        an[s] = 1'b0;
        v = d[4*s +: 4];
        return {an, HEX[v], ~dp[s]};
    endfunction

    task automatic model_reset();
        k = 0;
        m_act_d = '0; m_act_dp = '0; m_act_bm = '0;
        m_sh_d  = '0; m_sh_dp  = '0; m_sh_bm  = '0;
        m_has_sh = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, predict the registered outputs
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] bm, input bit blz);
        int f, s;
        bit ph;
        bus.digits = d; bus.dp_in = dp; bus.blink_mask = bm;
        bus.blank_lz = blz; bus.load = ld;
        @(posedge clk);
        k++;
        f  = (k - 1) / FRAME;
        s  = ((k - 1) / RD) % ND;
        ph = ((f / BD) % 2) == 1;
        exp_vec = {model_out(s, m_act_d, m_act_dp, m_act_bm, blz, ph), (k % FRAME) == 0};
        if (ld) begin
            m_sh_d = d; m_sh_dp = dp; m_sh_bm = bm; m_has_sh = 1'b1;
        end
        if ((k % FRAME) == 0 && m_has_sh) begin
            m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_bm = m_sh_bm; m_has_sh = 1'b0;
        end
        #1;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        bus.digits = 16'hABCD; bus.dp_in = 4'hF; bus.blink_mask = '0;
        bus.blank_lz = 1'b0; bus.load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec !== 13'h1FFE) begin
            n_errors++;
            $display("FAIL reset_async: got %b expected %b", obs_vec, 13'h1FFE);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec !== 13'h1FFE) begin
            n_errors++;
            $display("FAIL reset_held: got %b expected %b", obs_vec, 13'h1FFE);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        int ticks = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step(1'b0, 16'($urandom), 4'($urandom), 4'h0, 1'b0);
            if (bus.frame_tick) ticks++;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL scan k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (ticks !== 4) begin
            n_errors++;
            $display("FAIL frame_tick_count: got %0d expected %0d", ticks, 4);
        end
    endtask

    task automatic test_load_midframe();
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(i == 6, (i == 6) ? 16'h12AF : 16'($urandom), (i == 6) ? 4'b0100 : 4'($urandom),
                 4'h0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL load_midframe k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_blank_lz();
        for (int i = 0; i < 6 * FRAME; i++) begin
            step(i == 1 || i == 3 * FRAME, (i < 3 * FRAME) ? 16'h0005 : 16'h0000, 4'h0, 4'h0, 1'b1);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL blank_lz k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_blink();
        for (int i = 0; i < 9 * FRAME; i++) begin
            step(i == 0, 16'h8421, 4'b0001, 4'b0001, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL blink k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_load_on_tc();
        int guard = 0;
        while (((k + 1) % FRAME) != 0 && guard < 2 * FRAME) begin
            step(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
            guard++;
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            step(i == 0, 16'h3C7E, 4'b1001, 4'h0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL load_on_tc k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        bit blz = 1'b0;
        logic [15:0] d;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) blz = 1'($urandom);
            for (int n = 0; n < 4; n++) d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            step($urandom_range(0, 11) == 0, d, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 4'($urandom), blz);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL random k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        for (int i = 0; i < FRAME; i++) step(i == 0, 16'h9876, 4'b0110, 4'h0, 1'b0);
        while (((k - 1) / RD) % ND != 2 && guard < 2 * FRAME) begin
            step(1'b0, 16'h9876, 4'b0110, 4'h0, 1'b0);
            guard++;
        end
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL pre_reset_slot2: got %b expected %b", obs_vec, exp_vec);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec !== 13'h1FFE) begin
            n_errors++;
            $display("FAIL reset_midframe: got %b expected %b", obs_vec, 13'h1FFE);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h9876, 4'b0110, 4'h0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL after_reset k=%0d: got %b expected %b", k, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_load_midframe();
        test_blank_lz();
        test_blink();
        test_load_on_tc();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed seven-segment display driver for an N-digit common-anode display, replacing per-digit combinational decoding with a self-timed scanner. It sequences anode strobes from an internal refresh prescaler and decodes 4-bit hex digits to active-low segments. It also adds double-buffered digit loading, per-digit decimal points, per-digit blinking and optional leading-zero blanking. It sits between the clock/alarm time-keeping logic and the board display pins.

## Interface
- NUM_DIGITS, 4: digit count, ≥2.
- REFRESH_DIV, 100000: clock cycles per digit slot, ≥1.
- BLINK_DIV, 64: full scan frames per blink half-period, ≥1.
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- digits  in  4*NUM_DIGITS  hex digit values; digit i at [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- blank_lz  in  1  1 = enable leading-zero blanking.
- load  in  1  single-cycle strobe: capture digits/dp_in/blink_mask into shadow.
- anode  out  NUM_DIGITS  active-low digit enables, registered.
- segments  out  7  active-low {a,b,c,d,e,f,g}, registered.
- decimal  out  1  active-low decimal point, registered.
- frame_tick  out  1  one-cycle pulse when slot wraps to 0.

## Operation
- Reset: prescaler=0, slot=0, blink counter=0, blink_phase=0, shadow/active registers=0, pending=0; anode=all ones, segments=7'b1111111, decimal=1, frame_tick=0.
- Prescaler counts 0..REFRESH_DIV-1. Terminal count (TC) advances slot; slot wraps NUM_DIGITS-1 → 0, and that wrap asserts frame_tick for the following cycle.
- Double buffering: load captures inputs into shadow and sets pending. On a wrap with pending=1, shadow copies to active and pending clears. load on the wrap cycle itself bypasses the shadow: new inputs commit on that wrap. Display never changes data mid-frame.
- Blink: on every wrap the blink counter increments. At BLINK_DIV-1 it returns to 0 and blink_phase toggles.
- Per-slot output for digit s, computed from active registers:
  - Blanked if (blink_mask[s] && blink_phase) or leading-zero-blanked.
  - Blanked: anode all ones, segments 7'b1111111, decimal 1.
  - Otherwise: anode has only bit s low; segments = hex decode; decimal = ~dp[s].
- Leading-zero blanking (blank_lz=1): digit s is blanked iff every digit j ≥ s has value 0 and dp 0, and s ≠ 0. Digit 0 is never blanked by this rule.
- Hex decode (segments): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.

## Timing
- Registered outputs reflect the slot value one clock earlier: 1-cycle latency from slot change to anode/segments change.
- Each digit is driven for exactly REFRESH_DIV cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- With REFRESH_DIV=1, the slot advances every cycle and frame_tick fires every NUM_DIGITS cycles.
- Blink half-period is BLINK_DIV frames. The blink toggle and the data commit happen on the same wrap edge, so both take effect together on the first cycle of slot 0.
- Multiple loads within one frame: the last one wins. Commit is gated only by pending.
- Asynchronous reset mid-frame immediately forces the reset values above. The scan restarts at slot 0, prescaler 0, after rst_n deasserts.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4, reset release, no load -> slot 0 driven with anode=1110 and segments=0000001 for 4 cycles. Then 1101, 1011, 0111 for 4 cycles each. frame_tick pulses every 16 cycles.
- load digits=16'h12AF, dp_in=4'b0100 mid-frame -> no change until the next wrap. Then the F, A, 2, 1 patterns appear in order, and decimal=0 only while anode=1011.
- blank_lz=1, digits=16'h0005 -> anode stays 1111 in slots 1-3. Slot 0 shows 0100100. With digits=16'h0000, slot 0 shows 0000001 and slots 1-3 are blank.
- BLINK_DIV=2, blink_mask=4'b0001 -> digit 0 lit for 2 frames, then anode 1111 with segments 1111111 in slot 0 for 2 frames, repeating. Other digits are unaffected.
- load asserted on the exact TC cycle of slot 3 -> new data visible in slot 0 of the very next frame.
- rst_n pulsed low during slot 2 -> outputs go to all ones, decimal=1, frame_tick=0 asynchronously. After release, the scan resumes from slot 0 with active data cleared to 0.
